// File: rtl/dbg_trace_pkg.sv
// Shared definitions for the Minion data-bus trace buffer: register map, FSM encoding,
// and bit positions of the fields inside one trace RAM entry.
package dbg_trace_pkg;

  // Register word offsets.
  localparam logic [3:0] RegCtrl     = 4'd0;
  localparam logic [3:0] RegStatus   = 4'd1;
  localparam logic [3:0] RegTrigAddr = 4'd2;
  localparam logic [3:0] RegTrigMask = 4'd3;
  localparam logic [3:0] RegPostCnt  = 4'd4;
  localparam logic [3:0] RegRdIdx    = 4'd5;
  localparam logic [3:0] RegRdAddr   = 4'd6;
  localparam logic [3:0] RegRdWdata  = 4'd7;
  localparam logic [3:0] RegRdMeta   = 4'd8;

  // CTRL bit positions.
  localparam int unsigned CtrlArmBit    = 0;
  localparam int unsigned CtrlStopBit   = 1;
  localparam int unsigned CtrlWeOnlyBit = 2;

  // Capture FSM encoding; values are visible to software through STATUS[1:0].
  typedef logic [1:0] trace_state_t;
  localparam trace_state_t StIdle  = 2'd0;
  localparam trace_state_t StArmed = 2'd1;
  localparam trace_state_t StPost  = 2'd2;
  localparam trace_state_t StDone  = 2'd3;

  // Entry layout, LSB first: wdata, addr, be, we, ts.
  localparam int unsigned EntFixedW   = 69;
  localparam int unsigned EntWdataLsb = 0;
  localparam int unsigned EntAddrLsb  = 32;
  localparam int unsigned EntBeLsb    = 64;
  localparam int unsigned EntWeBit    = 68;
  localparam int unsigned EntTsLsb    = 69;

  function automatic int unsigned entry_width(int unsigned ts_w);
    return ts_w + EntFixedW;
  endfunction

endpackage

// File: rtl/dbg_trace_ram.sv
// Trace storage: one write port, one registered read port, no reset so that it maps onto
// block RAM. A read and write to the same address in one cycle returns the old contents.
module dbg_trace_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 85
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/dbg_trace_capture.sv
// Circular trace buffer for granted Minion data-bus requests with pre/post-trigger capture
// and a small 32-bit register port for software readback.
module dbg_trace_capture
  import dbg_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 256,  // power of 2, 16..256
  parameter int unsigned TS_W  = 16
) (
  input  logic        msoc_clk,
  input  logic        rst_top,
  input  logic        core_req,
  input  logic        core_gnt,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_be,
  input  logic        reg_sel,
  input  logic        reg_we,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic        trig_out
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned EW      = entry_width(TS_W);
  localparam logic [7:0]  PostMax = 8'(DEPTH - 1);

  // Capture state
  trace_state_t  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic [7:0]    post_cnt_q, post_cnt_d;
  logic          wrapped_q, wrapped_d;
  logic [TS_W-1:0] ts_q;
  logic          trig_out_q;

  // Configuration registers
  logic [31:0]   trig_addr_q;
  logic [31:0]   trig_mask_q;
  logic [7:0]    post_cfg_q;
  logic [AW-1:0] rd_idx_q;
  logic          we_only_q;

  // Read response path
  logic          rvalid_q;
  logic          rd_ram_q;
  logic [3:0]    rd_off_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_mux;
  logic [31:0]   ram_field;
  logic [31:0]   meta;

  logic          sample, capture, trig_hit;
  logic          reg_wr, reg_rd, ctrl_arm, ctrl_stop;
  logic [7:0]    post_clamp;
  logic [EW-1:0] ram_wdata, ram_rdata;

  assign sample    = core_req & core_gnt;
  assign capture   = sample & ((state_q == StArmed) | (state_q == StPost));
  assign trig_hit  = sample & (state_q == StArmed) &
                     (((core_addr ^ trig_addr_q) & trig_mask_q) == 32'h0) &
                     (core_we | ~we_only_q);

  assign reg_wr    = reg_sel & reg_we;
  assign reg_rd    = reg_sel & ~reg_we;
  assign ctrl_arm  = reg_wr & (reg_addr == RegCtrl) & reg_wdata[CtrlArmBit];
  assign ctrl_stop = reg_wr & (reg_addr == RegCtrl) & reg_wdata[CtrlStopBit];

  assign post_clamp = (post_cfg_q > PostMax) ? PostMax : post_cfg_q;

  assign ram_wdata = {ts_q, core_we, core_be, core_addr, core_wdata};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    post_cnt_d = post_cnt_q;
    wrapped_d  = wrapped_q;

    if (capture) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (wr_ptr_d == '0) begin
        wrapped_d = 1'b1;
      end
    end

    if (trig_hit) begin
      trig_ptr_d = wr_ptr_q;
      post_cnt_d = post_clamp;
      state_d    = (post_clamp == 8'd0) ? StDone : StPost;
    end else if (capture && (state_q == StPost)) begin
      post_cnt_d = post_cnt_q - 8'd1;
      if (post_cnt_d == 8'd0) begin
        state_d = StDone;
      end
    end

    // Software control overrides whatever the sample in this cycle would have done.
    if (ctrl_arm) begin
      state_d   = StArmed;
      wr_ptr_d  = '0;
      wrapped_d = 1'b0;
    end else if (ctrl_stop && ((state_q == StArmed) || (state_q == StPost))) begin
      state_d = StDone;
    end
  end

  always_ff @(posedge msoc_clk or posedge rst_top) begin
    if (rst_top) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
      ts_q       <= '0;
      trig_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      post_cnt_q <= post_cnt_d;
      wrapped_q  <= wrapped_d;
      ts_q       <= ts_q + TS_W'(1);
      trig_out_q <= trig_hit;
    end
  end

  always_ff @(posedge msoc_clk or posedge rst_top) begin
    if (rst_top) begin
      trig_addr_q <= '0;
      trig_mask_q <= '0;
      post_cfg_q  <= '0;
      rd_idx_q    <= '0;
      we_only_q   <= 1'b0;
    end else if (reg_wr) begin
      case (reg_addr)
        RegCtrl:     we_only_q   <= reg_wdata[CtrlWeOnlyBit];
        RegTrigAddr: trig_addr_q <= reg_wdata;
        RegTrigMask: trig_mask_q <= reg_wdata;
        RegPostCnt:  post_cfg_q  <= reg_wdata[7:0];
        RegRdIdx:    rd_idx_q    <= reg_wdata[AW-1:0];
        default: ;
      endcase
    end
  end

  dbg_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk_i   (msoc_clk),
    .we_i    (capture),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (rd_idx_q),
    .rdata_o (ram_rdata)
  );

  // Non-RAM registers are snapshotted at the strobe.
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      RegCtrl:     rd_mux[CtrlWeOnlyBit] = we_only_q;
      RegStatus: begin
        rd_mux[1:0]     = state_q;
        rd_mux[8 +: AW] = wr_ptr_q;
        rd_mux[16 +: AW] = trig_ptr_q;
        rd_mux[31]      = wrapped_q;
      end
      RegTrigAddr: rd_mux = trig_addr_q;
      RegTrigMask: rd_mux = trig_mask_q;
      RegPostCnt:  rd_mux[7:0] = post_cfg_q;
      RegRdIdx:    rd_mux[AW-1:0] = rd_idx_q;
      default: ;
    endcase
  end

  // RAM-backed registers come straight from the RAM output register, which was
  // addressed by RD_IDX in the strobe cycle.
  always_comb begin
    meta              = '0;
    meta[31 -: TS_W]  = ram_rdata[EntTsLsb +: TS_W];
    meta[4]           = ram_rdata[EntWeBit];
    meta[3:0]         = ram_rdata[EntBeLsb +: 4];
    ram_field         = '0;
    case (rd_off_q)
      RegRdAddr:  ram_field = ram_rdata[EntAddrLsb +: 32];
      RegRdWdata: ram_field = ram_rdata[EntWdataLsb +: 32];
      RegRdMeta:  ram_field = meta;
      default: ;
    endcase
    reg_rdata = rd_ram_q ? ram_field : rdata_q;
  end

  always_ff @(posedge msoc_clk or posedge rst_top) begin
    if (rst_top) begin
      rvalid_q <= 1'b0;
      rd_ram_q <= 1'b0;
      rd_off_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= reg_rd;
      if (reg_rd) begin
        rd_ram_q <= (reg_addr == RegRdAddr) | (reg_addr == RegRdWdata) |
                    (reg_addr == RegRdMeta);
        rd_off_q <= reg_addr;
        rdata_q  <= rd_mux;
      end
    end
  end

  assign reg_rvalid = rvalid_q;
  assign trig_out   = trig_out_q;

endmodule

// File: tb/tb_dbg_trace_capture.sv
// Directed bench for dbg_trace_capture: stimulus pushes expected read data and trigger
// pulse times into queues; a negedge monitor pops and compares them.
module tb_dbg_trace_capture;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 16;

  localparam logic [3:0] OCtrl = 4'd0, OStatus = 4'd1, OTrigAddr = 4'd2, OTrigMask = 4'd3;
  localparam logic [3:0] OPostCnt = 4'd4, ORdIdx = 4'd5, ORdAddr = 4'd6, ORdWdata = 4'd7;
  localparam logic [3:0] ORdMeta = 4'd8, OUnmapped = 4'd9;

  logic        msoc_clk = 1'b0;
  logic        rst_top  = 1'b1;
  logic        core_req, core_gnt, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_be;
  logic        reg_sel, reg_we;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        trig_out;

  dbg_trace_capture #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .msoc_clk   (msoc_clk),
    .rst_top    (rst_top),
    .core_req   (core_req),
    .core_gnt   (core_gnt),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_be    (core_be),
    .reg_sel    (reg_sel),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .trig_out   (trig_out)
  );

  always #5 msoc_clk = ~msoc_clk;

  int cyc = 0;
  always @(posedge msoc_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    bit          neq;
    int          cyc;
    string       name;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      trig_q[$];
  int      n_vec = 0;
  int      n_err = 0;

  rd_exp_t mon_e;
  bit      mon_ok;
  int      mon_t;

  // Monitor: every rvalid / trig_out pulse must match the oldest outstanding expectation.
  always @(negedge msoc_clk) begin
    if (reg_rvalid) begin
      n_vec = n_vec + 1;
      if (rd_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_rvalid: rdata=%h at cycle %0d, required no response",
                 reg_rdata, cyc);
      end else begin
        mon_e  = rd_q.pop_front();
        mon_ok = mon_e.neq ? ((reg_rdata & mon_e.mask) != mon_e.exp)
                           : ((reg_rdata & mon_e.mask) == mon_e.exp);
        if (!mon_ok || (cyc != mon_e.cyc + 1)) begin
          n_err = n_err + 1;
          $display("FAIL %s: rdata=%h (mask %h) at cycle %0d, required %s%h at cycle %0d",
                   mon_e.name, reg_rdata, mon_e.mask, cyc, mon_e.neq ? "not " : "",
                   mon_e.exp, mon_e.cyc + 1);
        end
      end
    end
    if (trig_out) begin
      n_vec = n_vec + 1;
      if (trig_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_trig: trig_out=1 at cycle %0d, required 0", cyc);
      end else begin
        mon_t = trig_q.pop_front();
        if (cyc != mon_t + 1) begin
          n_err = n_err + 1;
          $display("FAIL trig_timing: trig_out at cycle %0d, required cycle %0d", cyc, mon_t + 1);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                     input bit trig);
    core_req   = 1'b1;
    core_gnt   = 1'b1;
    core_we    = we;
    core_addr  = addr;
    core_wdata = addr ^ 32'hA5A5_0000;
    core_be    = be;
    if (trig) trig_q.push_back(cyc);
    @(posedge msoc_clk); #1;
    core_req = 1'b0;
    core_gnt = 1'b0;
  endtask

  task automatic reg_wr(input logic [3:0] off, input logic [31:0] data);
    reg_sel   = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = off;
    reg_wdata = data;
    @(posedge msoc_clk); #1;
    reg_sel = 1'b0;
    reg_we  = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] off, input logic [31:0] exp, input logic [31:0] mask,
                        input bit neq, input string name);
    rd_exp_t e;
    e.exp  = exp;
    e.mask = mask;
    e.neq  = neq;
    e.cyc  = cyc;
    e.name = name;
    rd_q.push_back(e);
    reg_sel  = 1'b1;
    reg_we   = 1'b0;
    reg_addr = off;
    @(posedge msoc_clk); #1;
    reg_sel = 1'b0;
  endtask

  localparam logic [31:0] All = 32'hFFFF_FFFF;

  initial begin
    core_req = 0; core_gnt = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_be = 0;
    reg_sel = 0; reg_we = 0; reg_addr = 0; reg_wdata = 0;
    repeat (3) @(posedge msoc_clk);
    #1;
    check("rst_rvalid", {31'b0, reg_rvalid}, 32'h0);
    check("rst_trig",   {31'b0, trig_out},   32'h0);
    check("rst_rdata",  reg_rdata,           32'h0);
    rst_top = 1'b0;
    @(posedge msoc_clk); #1;

    // Idle: samples ignored until ARM; reset TRIG_MASK=0 matches anything.
    bus(32'h10, 1, 4'hF, 0);
    bus(32'h14, 1, 4'hF, 0);
    reg_rd(OStatus, 32'h0, All, 0, "idle_status");
    reg_wr(OCtrl, 32'h1);
    bus(32'h20, 1, 4'hF, 1);
    reg_rd(OStatus, 32'h0000_0103, All, 0, "post0_done_status");
    reg_wr(OTrigAddr, 32'h55);
    repeat (3) @(posedge msoc_clk);
    #2 rst_top = 1'b1;
    repeat (2) @(posedge msoc_clk);
    #1;
    check("midrst_rvalid", {31'b0, reg_rvalid}, 32'h0);
    check("midrst_trig",   {31'b0, trig_out},   32'h0);
    check("midrst_rdata",  reg_rdata,           32'h0);
    rst_top = 1'b0;
    @(posedge msoc_clk); #1;
    bus(32'h30, 1, 4'hF, 0);
    bus(32'h34, 1, 4'hF, 0);
    reg_rd(OStatus,   32'h0, All, 0, "after_rst_status");
    reg_rd(OTrigAddr, 32'h0, All, 0, "after_rst_trig_addr");
    reg_rd(OCtrl,     32'h0, All, 0, "after_rst_ctrl");

    // Basic capture
    reg_wr(OTrigMask, All);
    reg_wr(OTrigAddr, 32'h100);
    reg_wr(OPostCnt, 32'h3);
    reg_wr(OCtrl, 32'h1);
    reg_rd(OStatus, 32'h0000_0001, All, 0, "armed_status");
    core_req = 1'b1; core_gnt = 1'b0; core_addr = 32'h100; core_we = 1'b1;
    @(posedge msoc_clk); #1;
    core_req = 1'b0;
    bus(32'h0F0, 1, 4'hF, 0);
    bus(32'h0F4, 1, 4'hF, 0);
    bus(32'h100, 1, 4'hF, 1);
    bus(32'h104, 1, 4'hF, 0);
    bus(32'h108, 1, 4'hF, 0);
    reg_rd(OStatus, 32'h0002_0502, All, 0, "post_status");
    bus(32'h10C, 1, 4'hF, 0);
    bus(32'h110, 1, 4'hF, 0);
    reg_rd(OStatus, 32'h0002_0603, All, 0, "basic_done_status");
    reg_wr(ORdIdx, 32'h2);
    reg_rd(ORdAddr,  32'h0000_0100, All, 0, "rd_addr_idx2");
    reg_rd(ORdWdata, 32'hA5A5_0100, All, 0, "rd_wdata_idx2");
    reg_rd(ORdMeta,  32'h0000_001F, 32'h0000_FFFF, 0, "rd_meta_idx2");
    reg_wr(ORdIdx, 32'h5);
    reg_rd(ORdAddr,  32'h0000_010C, All, 0, "rd_addr_idx5");
    reg_wr(ORdIdx, 32'h6);
    reg_rd(ORdAddr,  32'h0000_0110, All, 1, "entry6_unwritten");
    reg_wr(ORdIdx, 32'h12);
    reg_rd(ORdIdx,   32'h2, All, 0, "rd_idx_masked");
    reg_rd(ORdAddr,  32'h0000_0100, All, 0, "rd_addr_masked_idx");
    reg_wr(OUnmapped, 32'hDEAD_BEEF);
    reg_rd(OUnmapped, 32'h0, All, 0, "unmapped");
    reg_rd(OTrigAddr, 32'h100, All, 0, "trig_addr_rb");
    reg_rd(OTrigMask, All, All, 0, "trig_mask_rb");
    reg_rd(OPostCnt, 32'h3, All, 0, "post_cnt_rb");

    // Wrap with clamped post count
    reg_wr(OTrigMask, 32'h0);
    reg_wr(OPostCnt, 32'hFF);
    reg_rd(OPostCnt, 32'hFF, All, 0, "post_cnt_ff");
    reg_wr(OCtrl, 32'h1);
    for (int i = 0; i < 15; i++) bus(32'h2000 + 32'(4 * i), 1, 4'hF, i == 0);
    reg_rd(OStatus, 32'h0000_0F02, All, 0, "wrap_15_status");
    bus(32'h203C, 1, 4'hF, 0);
    reg_rd(OStatus, 32'h8000_0003, All, 0, "wrap_16_status");
    for (int i = 16; i < 40; i++) bus(32'h2000 + 32'(4 * i), 1, 4'hF, 0);
    reg_rd(OStatus, 32'h8000_0003, All, 0, "wrap_40_status");
    reg_wr(ORdIdx, 32'hF);
    reg_rd(ORdAddr, 32'h203C, All, 0, "wrap_idx15");
    reg_wr(ORdIdx, 32'h0);
    reg_rd(ORdAddr, 32'h2000, All, 0, "wrap_idx0");

    // WE_ONLY
    reg_wr(OTrigMask, All);
    reg_wr(OTrigAddr, 32'h300);
    reg_wr(OPostCnt, 32'h0);
    reg_wr(OCtrl, 32'h5);
    reg_rd(OCtrl, 32'h4, All, 0, "ctrl_we_only");
    bus(32'h300, 0, 4'hC, 0);
    bus(32'h300, 0, 4'hC, 0);
    bus(32'h304, 1, 4'hF, 0);
    bus(32'h300, 1, 4'h3, 1);
    reg_rd(OStatus, 32'h0003_0403, All, 0, "we_only_status");
    reg_wr(ORdIdx, 32'h3);
    reg_rd(ORdMeta,  32'h0000_0013, 32'h0000_FFFF, 0, "we_only_meta_trig");
    reg_rd(ORdWdata, 32'hA5A5_0300, All, 0, "we_only_wdata");
    reg_wr(ORdIdx, 32'h0);
    reg_rd(ORdMeta,  32'h0000_000C, 32'h0000_FFFF, 0, "we_only_meta_read");

    // Re-arm during POST, then STOP and ARM+STOP
    reg_wr(OTrigAddr, 32'h500);
    reg_wr(OPostCnt, 32'h5);
    reg_wr(OCtrl, 32'h1);
    reg_rd(OCtrl, 32'h0, All, 0, "ctrl_cleared");
    for (int i = 0; i < 18; i++) bus(32'h4000 + 32'(4 * i), 0, 4'hF, 0);
    reg_rd(OStatus, 32'h8003_0201, All, 0, "armed_wrapped_status");
    bus(32'h500, 0, 4'hF, 1);
    bus(32'h4100, 0, 4'hF, 0);
    reg_rd(OStatus, 32'h8002_0402, All, 0, "post_wrapped_status");
    reg_wr(OCtrl, 32'h1);
    reg_rd(OStatus, 32'h0002_0001, All, 0, "rearm_status");
    reg_wr(OCtrl, 32'h2);
    reg_rd(OStatus, 32'h0002_0003, All, 0, "stop_status");
    reg_wr(OCtrl, 32'h3);
    reg_rd(OStatus, 32'h0002_0001, All, 0, "arm_stop_status");

    for (int i = 0; i < 20 && (rd_q.size() != 0 || trig_q.size() != 0); i++)
      @(posedge msoc_clk);
    #1;
    check("reads_outstanding", 32'(rd_q.size()), 32'h0);
    check("trigs_outstanding", 32'(trig_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
